down_timer: RTL and testbench
=============================

# down_timer

Loadable down-counting timer: the decrementing counterpart to the team's 8-bit up-counter. It reloads from a programmed value, counts down one step per enabled cycle, and signals expiry. Counter blocks use it to generate timeouts and periodic ticks, and the up-counter's formal bench reuses it as a reference event source.

## Interface
- WIDTH, 8, counter and load-value width in bits (WIDTH >= 2)
- AUTO_RELOAD, 0, 1 = reload and keep running on expiry; 0 = stop in DONE

- clk  input  1  single clock; all logic on posedge clk
- reset  input  1  synchronous, active-high; overrides every other input
- ena  input  1  count enable; result holds when low
- load  input  1  one-cycle strobe: capture load_value and start
- load_value  input  WIDTH  start/reload count (unsigned)
- clr  input  1  abort: return to IDLE, result <= 0
- result  output  WIDTH  current count (registered)
- busy  output  1  high in RUN
- done  output  1  high in DONE (AUTO_RELOAD=0 only)
- zero  output  1  result == 0 (decoded from the result register)
- expired  output  1  one-cycle registered pulse on each expiry

## Operation
- States: IDLE, RUN, DONE. An internal reload_reg (WIDTH bits) holds the last loaded value.
- Input priority per cycle: reset > clr > load > ena-count.
- reset: state IDLE, result 0, reload_reg 0, expired 0. Outputs: busy 0, done 0, zero 1.
- clr (any state): state IDLE, result 0, expired 0. reload_reg is unchanged.
- load (any state, clr low): result <= load_value, reload_reg <= load_value.
  - load_value != 0: next state RUN.
  - load_value == 0: next state IDLE, no expired pulse.
  - A load in RUN restarts the count, discards the in-progress count, and produces no expired pulse for it.
- RUN, ena high, result > 1: result <= result - 1.
- RUN, ena high, result == 1: expiry. expired <= 1 in the next cycle.
  - AUTO_RELOAD=0: result <= 0, state DONE.
  - AUTO_RELOAD=1: result <= reload_reg, stays RUN. The count never shows 0.
  - reload_reg == 1 under AUTO_RELOAD=1: expired pulses on every enabled cycle.
- RUN, ena low: result, state and reload_reg hold; expired is 0.
- IDLE and DONE ignore ena. result holds 0 or the loaded 0.
- Arithmetic is unsigned modulo 2^WIDTH, but underflow past 0 never occurs: the decrement only fires when result >= 2.

## Timing
- Every output is registered or decoded from registers only; there is no combinational path from any input to any output.
- load asserted in cycle n: result == load_value and busy == 1 from cycle n+1.
- Expiry latency: load_value = N with ena held high expires N enabled cycles after the load takes effect.
  - The N-th enabled cycle in RUN is the expiry cycle.
  - expired is high for exactly one cycle, the one following that cycle.
  - With AUTO_RELOAD=0, done rises in that same cycle.
- AUTO_RELOAD=1 with ena held high: expired period is exactly reload_reg cycles.
- load coincident with expiry: load wins. Result is the new value, no expired pulse.
- clr coincident with load: clr wins.
- reset mid-RUN: next cycle matches the reset values above; no expired pulse.

## Test plan
- Reset: assert reset for 2 cycles from random state -> result 0, zero 1, busy 0, done 0, expired 0.
- One-shot: AUTO_RELOAD=0, load 5, ena high -> result 5,4,3,2,1,0; expired pulses once with result 0; done stays 1 and result stays 0 for 10 further cycles.
- Enable gating: load 4, toggle ena 1,0,0,1,1,0,1 -> result only changes on ena-high cycles; expired follows the 4th enabled cycle.
- Auto-reload: AUTO_RELOAD=1, load 3, ena high 12 cycles -> result 3,2,1,3,2,1,...; expired every 3 cycles; zero never 1.
- Edge loads: load 0 -> IDLE, no expired; load 1 -> expired after 1 enabled cycle; load 255 -> 255 steps, no wrap.
- Collisions: load 7 on the expiry cycle -> result 7, no expired; clr+load together -> IDLE, result 0; reset mid-RUN at result 3 -> reset values, no expired.

Source files
------------

// File: rtl/down_timer.sv
// Loadable down-counting timer with expiry pulse; stops in DONE or
// reloads from the last loaded value, depending on AUTO_RELOAD.
module down_timer #(
    parameter int WIDTH       = 8,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clr,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             expired
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] reload_reg;

    // busy/done are registered alongside state so they never depend on inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            result     <= '0;
            reload_reg <= '0;
            expired    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (clr) begin
                state  <= IDLE;
                result <= '0;
                busy   <= 1'b0;
                done   <= 1'b0;
            end else if (load) begin
                result     <= load_value;
                reload_reg <= load_value;
                done       <= 1'b0;
                if (load_value != '0) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else if (state == RUN && ena) begin
                if (result > ONE) begin
                    result <= result - ONE;
                end else if (result == ONE) begin
                    expired <= 1'b1;
                    if (AUTO_RELOAD) begin
                        result <= reload_reg;
                    end else begin
                        result <= '0;
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
            end
        end
    end

    assign zero = (result == '0);

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: one-shot instance (u_once) and
// auto-reload instance (u_auto) share the same stimulus.
module tb_down_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ena = 1'b0;
    logic       load = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] load_value = 8'd0;

    logic [7:0] r0, r1;
    logic       busy0, done0, zero0, exp0;
    logic       busy1, done1, zero1, exp1;

    int total = 0;
    int bad = 0;

    down_timer #(.WIDTH(8), .AUTO_RELOAD(1'b0)) u_once (
        .clk(clk), .reset(reset), .ena(ena), .load(load), .load_value(load_value),
        .clr(clr), .result(r0), .busy(busy0), .done(done0), .zero(zero0), .expired(exp0)
    );

    down_timer #(.WIDTH(8), .AUTO_RELOAD(1'b1)) u_auto (
        .clk(clk), .reset(reset), .ena(ena), .load(load), .load_value(load_value),
        .clr(clr), .result(r1), .busy(busy1), .done(done1), .zero(zero1), .expired(exp1)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        load = 1'b1; load_value = 8'd9; ena = 1'b1;
        tick;
        load = 1'b0;
        tick; tick;
        reset = 1'b1;
        repeat (2) begin
            tick;
            total++;
            if ({r0, zero0, busy0, done0, exp0} !== {8'd0, 4'b1000}) begin
                bad++;
                $display("[TB] FAIL reset_once got r=%0d z=%b b=%b d=%b e=%b want r=0 z=1 b=0 d=0 e=0",
                         r0, zero0, busy0, done0, exp0);
            end
            total++;
            if ({r1, zero1, busy1, done1, exp1} !== {8'd0, 4'b1000}) begin
                bad++;
                $display("[TB] FAIL reset_auto got r=%0d z=%b b=%b d=%b e=%b want r=0 z=1 b=0 d=0 e=0",
                         r1, zero1, busy1, done1, exp1);
            end
        end
        reset = 1'b0;
        ena = 1'b0;
    endtask

    task automatic test_one_shot;
        int want_r [6] = '{5, 4, 3, 2, 1, 0};
        load = 1'b1; load_value = 8'd5; ena = 1'b1;
        tick;
        load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick;
            total++;
            if ({r0, exp0, done0, busy0} !== {8'(want_r[i]), i == 5, i == 5, i != 5}) begin
                bad++;
                $display("[TB] FAIL one_shot[%0d] got r=%0d e=%b d=%b b=%b want r=%0d e=%b d=%b b=%b",
                         i, r0, exp0, done0, busy0, want_r[i], i == 5, i == 5, i != 5);
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick;
            total++;
            if ({r0, exp0, done0, zero0} !== {8'd0, 3'b011}) begin
                bad++;
                $display("[TB] FAIL one_shot_hold[%0d] got r=%0d e=%b d=%b z=%b want r=0 e=0 d=1 z=1",
                         i, r0, exp0, done0, zero0);
            end
        end
        ena = 1'b0;
    endtask

    task automatic test_enable_gating;
        logic pattern [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int   want_r [7] = '{3, 3, 3, 2, 1, 1, 0};
        load = 1'b1; load_value = 8'd4; ena = 1'b0;
        tick;
        load = 1'b0;
        total++;
        if ({r0, busy0, done0} !== {8'd4, 2'b10}) begin
            bad++;
            $display("[TB] FAIL gate_load got r=%0d b=%b d=%b want r=4 b=1 d=0", r0, busy0, done0);
        end
        for (int k = 0; k < 7; k++) begin
            ena = pattern[k];
            tick;
            total++;
            if ({r0, exp0} !== {8'(want_r[k]), k == 6}) begin
                bad++;
                $display("[TB] FAIL gate[%0d] got r=%0d e=%b want r=%0d e=%b",
                         k, r0, exp0, want_r[k], k == 6);
            end
        end
        ena = 1'b0;
    endtask

    task automatic test_auto_reload;
        int want_r [3] = '{2, 1, 3};
        load = 1'b1; load_value = 8'd3; ena = 1'b1;
        tick;
        load = 1'b0;
        total++;
        if ({r1, exp1, busy1} !== {8'd3, 2'b01}) begin
            bad++;
            $display("[TB] FAIL auto_load got r=%0d e=%b b=%b want r=3 e=0 b=1", r1, exp1, busy1);
        end
        for (int k = 0; k < 12; k++) begin
            tick;
            total++;
            if ({r1, exp1, zero1, busy1, done1} !== {8'(want_r[k % 3]), k % 3 == 2, 3'b010}) begin
                bad++;
                $display("[TB] FAIL auto[%0d] got r=%0d e=%b z=%b b=%b d=%b want r=%0d e=%b z=0 b=1 d=0",
                         k, r1, exp1, zero1, busy1, done1, want_r[k % 3], k % 3 == 2);
            end
        end
        // A reload value of 1 expires on every enabled cycle
        load = 1'b1; load_value = 8'd1;
        tick;
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            total++;
            if ({r1, exp1} !== {8'd1, 1'b1}) begin
                bad++;
                $display("[TB] FAIL auto_one[%0d] got r=%0d e=%b want r=1 e=1", k, r1, exp1);
            end
        end
        ena = 1'b0;
    endtask

    task automatic test_edge_loads;
        ena = 1'b1;
        load = 1'b1; load_value = 8'd0;
        tick;
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick;
            total++;
            if ({r0, busy0, done0, exp0, zero0} !== {8'd0, 4'b0001}) begin
                bad++;
                $display("[TB] FAIL load_zero[%0d] got r=%0d b=%b d=%b e=%b z=%b want r=0 b=0 d=0 e=0 z=1",
                         k, r0, busy0, done0, exp0, zero0);
            end
        end
        load = 1'b1; load_value = 8'd1;
        tick;
        load = 1'b0;
        total++;
        if ({r0, busy0, exp0} !== {8'd1, 2'b10}) begin
            bad++;
            $display("[TB] FAIL load_one got r=%0d b=%b e=%b want r=1 b=1 e=0", r0, busy0, exp0);
        end
        tick;
        total++;
        if ({r0, exp0, done0} !== {8'd0, 2'b11}) begin
            bad++;
            $display("[TB] FAIL load_one_exp got r=%0d e=%b d=%b want r=0 e=1 d=1", r0, exp0, done0);
        end
        load = 1'b1; load_value = 8'd255;
        tick;
        load = 1'b0;
        total++;
        if (r0 !== 8'd255) begin
            bad++;
            $display("[TB] FAIL load_max got r=%0d want r=255", r0);
        end
        for (int k = 1; k < 255; k++) begin
            tick;
            total++;
            if ({r0, exp0} !== {8'(255 - k), 1'b0}) begin
                bad++;
                $display("[TB] FAIL max_step[%0d] got r=%0d e=%b want r=%0d e=0", k, r0, exp0, 255 - k);
            end
        end
        tick;
        total++;
        if ({r0, exp0, done0} !== {8'd0, 2'b11}) begin
            bad++;
            $display("[TB] FAIL max_exp got r=%0d e=%b d=%b want r=0 e=1 d=1", r0, exp0, done0);
        end
        tick;
        total++;
        if ({r0, exp0} !== {8'd0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL max_nowrap got r=%0d e=%b want r=0 e=0", r0, exp0);
        end
        ena = 1'b0;
    endtask

    task automatic test_collisions;
        // Load 7 exactly on the cycle where result==1 would expire
        ena = 1'b1;
        load = 1'b1; load_value = 8'd2;
        tick;
        load = 1'b0;
        tick;
        load = 1'b1; load_value = 8'd7;
        tick;
        load = 1'b0;
        total++;
        if ({r0, exp0, busy0, done0} !== {8'd7, 3'b010}) begin
            bad++;
            $display("[TB] FAIL load_on_exp_once got r=%0d e=%b b=%b d=%b want r=7 e=0 b=1 d=0",
                     r0, exp0, busy0, done0);
        end
        total++;
        if ({r1, exp1} !== {8'd7, 1'b0}) begin
            bad++;
            $display("[TB] FAIL load_on_exp_auto got r=%0d e=%b want r=7 e=0", r1, exp1);
        end
        tick;
        total++;
        if ({r0, exp0} !== {8'd6, 1'b0}) begin
            bad++;
            $display("[TB] FAIL load_on_exp_next got r=%0d e=%b want r=6 e=0", r0, exp0);
        end
        clr = 1'b1; load = 1'b1; load_value = 8'd9;
        tick;
        clr = 1'b0; load = 1'b0;
        total++;
        if ({r0, busy0, done0, exp0, zero0} !== {8'd0, 4'b0001}) begin
            bad++;
            $display("[TB] FAIL clr_load_once got r=%0d b=%b d=%b e=%b z=%b want r=0 b=0 d=0 e=0 z=1",
                     r0, busy0, done0, exp0, zero0);
        end
        total++;
        if ({r1, busy1, exp1} !== {8'd0, 2'b00}) begin
            bad++;
            $display("[TB] FAIL clr_load_auto got r=%0d b=%b e=%b want r=0 b=0 e=0", r1, busy1, exp1);
        end
        load = 1'b1; load_value = 8'd5;
        tick;
        load = 1'b0;
        tick; tick;
        total++;
        if (r0 !== 8'd3) begin
            bad++;
            $display("[TB] FAIL pre_reset got r=%0d want r=3", r0);
        end
        reset = 1'b1; load = 1'b1; load_value = 8'd9;
        tick;
        reset = 1'b0; load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick;
            total++;
            if ({r0, zero0, busy0, done0, exp0} !== {8'd0, 4'b1000}) begin
                bad++;
                $display("[TB] FAIL mid_reset[%0d] got r=%0d z=%b b=%b d=%b e=%b want r=0 z=1 b=0 d=0 e=0",
                         k, r0, zero0, busy0, done0, exp0);
            end
        end
        ena = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tick;
        test_reset;
        test_one_shot;
        test_enable_gating;
        test_auto_reload;
        test_edge_loads;
        test_collisions;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
